// File: rtl/led_pkg.sv
// Shared definitions for the LED matrix scan controller: scan states and default geometry.
package led_pkg;

    typedef enum logic [2:0] {
        SETUP   = 3'd0,
        CLOCK   = 3'd1,
        BLANK   = 3'd2,
        LATCH   = 3'd3,
        ROWSEL  = 3'd4,
        DISPLAY = 3'd5
    } scan_state_t;

    localparam int COLS_DEF          = 32;
    localparam int ROWS_DEF          = 8;
    localparam int DISPLAY_TICKS_DEF = 64;

endpackage

// File: rtl/matrix_scan_ctrl_chk.sv
// Protocol checker for the scan controller outputs: latch only while dark,
// and serial data never moves while the shift clock is high.
module matrix_scan_ctrl_chk (
    input logic       clk,
    input logic       reset,
    input logic       blank,
    input logic       latch,
    input logic       sclk,
    input logic [2:0] leds1,
    input logic [2:0] leds2
);

    logic [5:0] leds_prev_r;

    // Remember the previous LED data so a change can be detected
    always_ff @(posedge clk) begin
        leds_prev_r <= {leds1, leds2};
    end

    // Output protocol properties, ignored while reset is held
    always @(posedge clk) begin
        if (reset) begin
            assert (!(latch && !blank));
            assert (!(sclk && ({leds1, leds2} != leds_prev_r)));
        end
    end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// HUB75-style row scan controller: shifts one row pair of RGB data, latches it,
// selects the row and keeps it lit for a fixed number of enable ticks.
module matrix_scan_ctrl
    import led_pkg::*;
#(
    parameter int COLS          = COLS_DEF,
    parameter int ROWS          = ROWS_DEF,
    parameter int DISPLAY_TICKS = DISPLAY_TICKS_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    shift_enb,
    output logic [$clog2(COLS)-1:0] col_addr,
    output logic [2:0]              row_addr,
    input  logic [2:0]              pix_top,
    input  logic [2:0]              pix_bot,
    output logic [2:0]              LEDs1,
    output logic [2:0]              LEDs2,
    output logic                    sclk,
    output logic                    blank,
    output logic                    latch,
    output logic [2:0]              rowSelect,
    output logic                    frame_done
);

    localparam int              CW        = $clog2(COLS);
    localparam logic [CW-1:0]   COL_LAST  = CW'(COLS - 1);
    localparam logic [2:0]      ROW_LAST  = 3'(ROWS - 1);
    localparam logic [7:0]      DISP_LAST = 8'(DISPLAY_TICKS - 1);

    scan_state_t state_r;
    logic [7:0]  disp_cnt_r;

    // Scan sequencer; all progress is gated by the external enable tick
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= SETUP;
            col_addr   <= {CW{1'b0}};
            row_addr   <= 3'd0;
            rowSelect  <= 3'd0;
            LEDs1      <= 3'd0;
            LEDs2      <= 3'd0;
            sclk       <= 1'b0;
            latch      <= 1'b0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            disp_cnt_r <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            if (shift_enb) begin
                case (state_r)
                    SETUP: begin
                        LEDs1   <= pix_top;
                        LEDs2   <= pix_bot;
                        sclk    <= 1'b0;
                        state_r <= CLOCK;
                    end
                    CLOCK: begin
                        sclk <= 1'b1;
                        if (col_addr == COL_LAST) begin
                            col_addr <= {CW{1'b0}};
                            state_r  <= BLANK;
                        end else begin
                            col_addr <= col_addr + CW'(1);
                            state_r  <= SETUP;
                        end
                    end
                    BLANK: begin
                        sclk    <= 1'b0;
                        blank   <= 1'b1;
                        state_r <= LATCH;
                    end
                    LATCH: begin
                        latch   <= 1'b1;
                        state_r <= ROWSEL;
                    end
                    ROWSEL: begin
                        // The freshly latched row lights up as DISPLAY is entered
                        latch      <= 1'b0;
                        rowSelect  <= row_addr;
                        blank      <= 1'b0;
                        disp_cnt_r <= 8'd0;
                        if (row_addr == ROW_LAST) begin
                            row_addr   <= 3'd0;
                            frame_done <= 1'b1;
                        end else begin
                            row_addr <= row_addr + 3'd1;
                        end
                        state_r <= DISPLAY;
                    end
                    DISPLAY: begin
                        if (disp_cnt_r == DISP_LAST) begin
                            blank      <= 1'b1;
                            disp_cnt_r <= 8'd0;
                            state_r    <= SETUP;
                        end else begin
                            disp_cnt_r <= disp_cnt_r + 8'd1;
                        end
                    end
                    default: begin
                        blank   <= 1'b1;
                        state_r <= SETUP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: tick-position reference model plus
// hand-computed expectations for latch timing, shifted data, frame pulse and holds.
module tb_matrix_scan_ctrl;
    import led_pkg::*;

    localparam int C = 32;
    localparam int R = 8;
    localparam int D = 64;
    localparam int P = 2 * C + 3 + D;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       shift_enb = 1'b0;
    logic [4:0] col_addr;
    logic [2:0] row_addr, pix_top, pix_bot, LEDs1, LEDs2, rowSelect;
    logic       sclk, blank, latch, frame_done;

    logic [2:0] top_mem [R][C];
    logic [2:0] bot_mem [R][C];

    assign pix_top = top_mem[row_addr][col_addr];
    assign pix_bot = bot_mem[row_addr][col_addr];

    always #5 clk = ~clk;

    matrix_scan_ctrl #(.COLS(C), .ROWS(R), .DISPLAY_TICKS(D)) dut (
        .clk(clk), .reset(reset), .shift_enb(shift_enb),
        .col_addr(col_addr), .row_addr(row_addr),
        .pix_top(pix_top), .pix_bot(pix_bot),
        .LEDs1(LEDs1), .LEDs2(LEDs2), .sclk(sclk), .blank(blank),
        .latch(latch), .rowSelect(rowSelect), .frame_done(frame_done)
    );

    matrix_scan_ctrl_chk chk (
        .clk(clk), .reset(reset), .blank(blank), .latch(latch),
        .sclk(sclk), .leds1(LEDs1), .leds2(LEDs2)
    );

    // Reference model: everything derives from the tick position within the row
    int         m_pos, m_row, m_col, tick_no;
    logic [2:0] m_l1, m_l2, m_rs;
    logic       m_sclk, m_blank, m_latch, m_fd;
    bit         chk_en = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_pos = 0; m_row = 0; m_col = 0; tick_no = 0;
        m_l1 = 3'd0; m_l2 = 3'd0; m_rs = 3'd0;
        m_sclk = 1'b0; m_blank = 1'b1; m_latch = 1'b0; m_fd = 1'b0;
    endfunction

    function automatic void model_tick();
        int pos = m_pos + 1;
        if (pos <= 2 * C) begin
            if (pos % 2 == 1) begin
                m_col  = (pos - 1) / 2;
                m_l1   = top_mem[m_row][m_col];
                m_l2   = bot_mem[m_row][m_col];
                m_sclk = 1'b0;
            end else begin
                m_sclk = 1'b1;
                m_col  = (pos / 2) % C;
            end
        end else if (pos == 2 * C + 1) begin
            m_sclk = 1'b0; m_blank = 1'b1;
        end else if (pos == 2 * C + 2) begin
            m_latch = 1'b1;
        end else if (pos == 2 * C + 3) begin
            m_latch = 1'b0; m_rs = 3'(m_row); m_blank = 1'b0;
            m_fd = (m_row == R - 1);
            m_row = (m_row + 1) % R;
        end else if (pos == P) begin
            m_blank = 1'b1;
        end
        m_pos = (pos == P) ? 0 : pos;
        tick_no++;
    endfunction

    task automatic step(input bit rst, input bit en);
        reset = !rst;
        shift_enb = en;
        @(posedge clk);
        m_fd = 1'b0;
        if (rst) model_reset();
        else if (en) model_tick();
        @(negedge clk);
    endtask

    // Compare every output against the model once per clock
    always @(negedge clk) begin
        if (chk_en) begin
            check("col_addr", col_addr, m_col);
            check("row_addr", row_addr, m_row);
            check("LEDs1", LEDs1, m_l1);
            check("LEDs2", LEDs2, m_l2);
            check("sclk", sclk, m_sclk);
            check("blank", blank, m_blank);
            check("latch", latch, m_latch);
            check("rowSelect", rowSelect, m_rs);
            check("frame_done", frame_done, m_fd);
        end
    end

    initial begin
        int first_latch, rs67, lo_first, lo_last, lo_cnt, bits, bad_bits;
        int fd_cnt, fd_tick, g, changes;
        logic ps;
        logic [2:0] cv;
        logic [20:0] snap;

        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                cv = 3'(c);
                top_mem[r][c] = cv;
                bot_mem[r][c] = ~cv;
            end
        model_reset();
        @(negedge clk);
        repeat (3) step(1'b1, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 1'b1);
        check("rst_blank", blank, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_latch", latch, 1'b0);
        check("rst_leds", {LEDs1, LEDs2}, 6'd0);
        check("rst_addr", {row_addr, col_addr, rowSelect}, 11'd0);

        // One row with a tick every 30 clocks and the column-index pattern
        first_latch = -1; rs67 = -1; lo_first = -1; lo_last = -1;
        lo_cnt = 0; bits = 0; bad_bits = 0; ps = 1'b0;
        for (int t = 1; t <= P; t++) begin
            repeat (29) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            if (latch && first_latch < 0) first_latch = t;
            if (t == 67) rs67 = int'(rowSelect);
            if (!blank) begin
                if (lo_first < 0) lo_first = t;
                lo_last = t;
                lo_cnt++;
            end
            if (sclk && !ps) begin
                cv = 3'(bits);
                if (LEDs1 !== cv || LEDs2 !== ~cv) bad_bits++;
                bits++;
            end
            ps = sclk;
        end
        check("first_latch_tick", first_latch, 66);
        check("rowsel_at_67", rs67, 0);
        check("blank_low_first", lo_first, 67);
        check("blank_low_last", lo_last, 130);
        check("blank_low_count", lo_cnt, 64);
        check("sclk_rises", bits, 32);
        check("shift_pattern_bad", bad_bits, 0);

        // Random pixels and random tick density over one full frame from reset
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                top_mem[r][c] = 3'($urandom);
                bot_mem[r][c] = 3'($urandom);
            end
        step(1'b1, 1'b0);
        fd_cnt = 0; fd_tick = -1; g = 0;
        while (tick_no < 8 * P && g < 20000) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            if (frame_done) begin fd_cnt++; fd_tick = tick_no; end
            g++;
        end
        check("frame_ticks", tick_no, 8 * P);
        check("frame_done_count", fd_cnt, 1);
        check("frame_done_tick", fd_tick, 7 * P + 67);
        check("row_wrap", row_addr, 3'd0);

        // Enable held low mid-shift: nothing may move
        g = 0;
        while (m_pos != 21 && g < 5000) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            g++;
        end
        check("reach_midshift", m_pos, 21);
        snap = {col_addr, row_addr, LEDs1, LEDs2, sclk, blank, latch, rowSelect, frame_done};
        changes = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 1'b0);
            if ({col_addr, row_addr, LEDs1, LEDs2, sclk, blank, latch, rowSelect, frame_done} !== snap)
                changes++;
        end
        check("hold_changes", changes, 0);

        // Reset while row 3 is on display
        g = 0;
        while (!(m_row == 4 && m_pos > 2 * C + 8) && g < 10000) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            g++;
        end
        check("reach_row3_display", {m_row == 4, blank}, {1'b1, 1'b0});
        step(1'b1, 1'b1);
        check("abort_blank", blank, 1'b1);
        check("abort_rowsel", rowSelect, 3'd0);
        check("abort_sclk", sclk, 1'b0);
        check("abort_addr", {row_addr, col_addr}, 8'd0);
        first_latch = -1; g = 0;
        while (tick_no < 70 && g < 2000) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            if (latch && first_latch < 0) first_latch = tick_no;
            g++;
        end
        check("post_abort_latch_tick", first_latch, 66);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
